// File: rtl/spirxdata_pkg.sv
// Shared constants, state encoding and helpers for the SD-card SPI
// receive data path (also used by the transmit-side CRC step).
package spirxdata_pkg;

  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  FILL_BYTE   = 8'hFF;
  localparam logic [3:0]  MIN_LGBLKSZ = 4'd4;
  localparam logic [3:0]  MAX_LGBLKSZ = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TOKEN = 3'd1,
    S_DATA  = 3'd2,
    S_CRC   = 3'd3,
    S_DRAIN = 3'd4
  } rx_state_t;

  // Out-of-range block sizes saturate to the nearest supported size.
  function automatic logic [3:0] clamp_lgblksz(input logic [3:0] lg);
    logic [3:0] res;
    if (lg < MIN_LGBLKSZ) begin
      res = MIN_LGBLKSZ;
    end else if (lg > MAX_LGBLKSZ) begin
      res = MAX_LGBLKSZ;
    end else begin
      res = lg;
    end
    return res;
  endfunction

endpackage

// File: rtl/spirxdata_crc.sv
// One-byte CRC16-CCITT step, MSB first; shared by the receive and
// transmit data paths.
module spicrc16_byte
  import spirxdata_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] w_crc;

  // Bit-serial division unrolled across the eight message bits.
  always_comb begin
    w_crc = i_crc;
    for (int i = 7; i >= 0; i--) begin
      if (w_crc[15] ^ i_byte[i]) begin
        w_crc = {w_crc[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        w_crc = {w_crc[14:0], 1'b0};
      end
    end
  end

  assign o_crc = w_crc;

endmodule

// File: rtl/spirxdata.sv
// SD-card SPI receive data-block engine: token hunt, big-endian word
// packing into a buffer half, trailing CRC16 check and status report.
module spirxdata
  import spirxdata_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int LGTIMEOUT = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [3:0]    i_lgblksz,
  input  logic          i_fifo,
  output logic          o_busy,
  input  logic          i_ll_busy,
  output logic          o_ll_stb,
  output logic [7:0]    o_ll_byte,
  input  logic          i_ll_stb,
  input  logic [7:0]    i_ll_byte,
  output logic          o_write,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_rxvalid,
  output logic [7:0]    o_response,
  output logic          o_crcerr,
  output logic          o_timeout
);

  rx_state_t             r_state, w_next;
  logic [3:0]            r_lgblksz;
  logic [9:0]            r_bytecnt;
  logic [LGTIMEOUT-1:0]  r_tocnt;
  logic [15:0]           r_crc;
  logic [7:0]            r_crchi;
  logic                  r_crcsel;
  logic [AW-1:0]         r_addr;
  logic                  r_write;
  logic [DW-1:0]         r_word;
  logic                  r_busy, r_ll_stb, r_rxvalid, r_crcerr, r_timeout;
  logic [7:0]            r_response;

  logic [15:0]           w_crc_next;
  logic [9:0]            w_lastbyte;
  logic                  w_is_token, w_is_errtok, w_to_expire, w_last;

  spicrc16_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (i_ll_byte),
    .o_crc  (w_crc_next)
  );

  assign w_lastbyte  = (10'd1 << r_lgblksz) - 10'd1;
  assign w_is_token  = (i_ll_byte == START_TOKEN);
  assign w_is_errtok = (i_ll_byte[7:4] == 4'h0);
  assign w_to_expire = &r_tocnt;
  assign w_last      = (r_bytecnt == w_lastbyte);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_TOKEN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_TOKEN: begin
        if (i_ll_stb && w_is_token) begin
          w_next = S_DATA;
        end else if (i_ll_stb && (w_is_errtok || w_to_expire)) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_TOKEN;
        end
      end
      S_DATA: begin
        if (i_ll_stb && w_last) begin
          w_next = S_CRC;
        end else begin
          w_next = S_DATA;
        end
      end
      S_CRC: begin
        if (i_ll_stb && r_crcsel) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_CRC;
        end
      end
      S_DRAIN: begin
        if (!i_ll_busy) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, status and handshake registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lgblksz  <= MIN_LGBLKSZ;
      r_bytecnt  <= 10'd0;
      r_tocnt    <= '0;
      r_crc      <= 16'h0000;
      r_crchi    <= 8'h00;
      r_crcsel   <= 1'b0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_word     <= '0;
      r_busy     <= 1'b0;
      r_ll_stb   <= 1'b0;
      r_rxvalid  <= 1'b0;
      r_crcerr   <= 1'b0;
      r_timeout  <= 1'b0;
      r_response <= 8'h00;
    end else begin
      r_write   <= 1'b0;
      r_rxvalid <= 1'b0;
      r_ll_stb  <= (w_next == S_TOKEN) || (w_next == S_DATA) || (w_next == S_CRC);
      // Index saturates at the top of the half so a full block never wraps.
      if (r_write && (r_addr[AW-2:0] != {(AW-1){1'b1}})) begin
        r_addr[AW-2:0] <= r_addr[AW-2:0] + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy     <= 1'b1;
            r_lgblksz  <= clamp_lgblksz(i_lgblksz);
            r_addr     <= {i_fifo, {(AW-1){1'b0}}};
            r_crc      <= 16'h0000;
            r_tocnt    <= '0;
            r_bytecnt  <= 10'd0;
            r_crcsel   <= 1'b0;
            r_crcerr   <= 1'b0;
            r_timeout  <= 1'b0;
            r_response <= 8'h00;
          end
        end
        S_TOKEN: begin
          if (i_ll_stb && !w_is_token) begin
            if (w_is_errtok) begin
              r_response <= i_ll_byte;
            end else begin
              r_tocnt <= r_tocnt + 1'b1;
              if (w_to_expire) begin
                r_timeout  <= 1'b1;
                r_response <= FILL_BYTE;
              end
            end
          end
        end
        S_DATA: begin
          if (i_ll_stb) begin
            r_word    <= {r_word[DW-9:0], i_ll_byte};
            r_crc     <= w_crc_next;
            r_bytecnt <= r_bytecnt + 10'd1;
            if (r_bytecnt[1:0] == 2'b11) begin
              r_write <= 1'b1;
            end
          end
        end
        S_CRC: begin
          if (i_ll_stb) begin
            if (!r_crcsel) begin
              r_crchi  <= i_ll_byte;
              r_crcsel <= 1'b1;
            end else begin
              r_crcerr   <= ({r_crchi, i_ll_byte} != r_crc);
              r_response <= START_TOKEN;
            end
          end
        end
        S_DRAIN: begin
          if (!i_ll_busy) begin
            r_rxvalid <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_ll_stb   = r_ll_stb;
  assign o_ll_byte  = FILL_BYTE;
  assign o_write    = r_write;
  assign o_addr     = r_addr;
  assign o_data     = r_word;
  assign o_rxvalid  = r_rxvalid;
  assign o_response = r_response;
  assign o_crcerr   = r_crcerr;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_spirxdata.sv
// Directed bench for spirxdata: a byte-level card model feeds the DUT,
// writes and completion status are compared against bench-built values.
module tb_spirxdata;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  i_lgblksz = 4'd4;
  logic        i_fifo = 1'b0;
  logic        o_busy;
  logic        i_ll_busy = 1'b0;
  logic        o_ll_stb;
  logic [7:0]  o_ll_byte;
  logic        i_ll_stb = 1'b0;
  logic [7:0]  i_ll_byte = 8'hFF;
  logic        o_write;
  logic [7:0]  o_addr;
  logic [31:0] o_data;
  logic        o_rxvalid;
  logic [7:0]  o_response;
  logic        o_crcerr;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  spirxdata #(.DW(32), .AW(8), .LGTIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_lgblksz(i_lgblksz),
    .i_fifo(i_fifo), .o_busy(o_busy), .i_ll_busy(i_ll_busy), .o_ll_stb(o_ll_stb),
    .o_ll_byte(o_ll_byte), .i_ll_stb(i_ll_stb), .i_ll_byte(i_ll_byte),
    .o_write(o_write), .o_addr(o_addr), .o_data(o_data), .o_rxvalid(o_rxvalid),
    .o_response(o_response), .o_crcerr(o_crcerr), .o_timeout(o_timeout)
  );

  logic [7:0]  card [0:599];
  int          card_len;
  logic [7:0]  wr_addr [0:199];
  logic [31:0] wr_data [0:199];
  int          nwr;
  bit          rx_seen;
  logic [7:0]  rx_resp;
  logic        rx_crcerr, rx_timeout, rx_busy;
  int          drop_idx;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] crc;
  bit          saw_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC16-CCITT (init 0, MSB first) over card[first +: n].
  function automatic logic [15:0] crc_card(input int first, input int n);
    logic [15:0] c = 16'h0000;
    logic        fb;
    for (int j = first; j < first + n; j++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ card[j][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic do_start(input logic [3:0] lg, input logic fifo);
    @(negedge i_clk);
    i_start = 1'b1;
    i_lgblksz = lg;
    i_fifo = fifo;
  endtask

  // Card/low-level engine model: accepts o_ll_stb, stays busy for `gap`
  // cycles, then returns the next card byte (0xFF once the card runs out).
  task automatic run_xfer(input int gap, input int restart_at, input int abort_at, input int maxcyc);
    int idx = 0;
    int phase = 0;
    int cnt = 0;
    nwr = 0; rx_seen = 1'b0; drop_idx = -1;
    for (int cyc = 0; cyc < maxcyc; cyc++) begin
      @(negedge i_clk);
      if (o_write && nwr < 200) begin
        wr_addr[nwr] = o_addr;
        wr_data[nwr] = o_data;
        nwr++;
      end
      if (!o_ll_stb && drop_idx < 0) drop_idx = idx;
      if (o_rxvalid) begin
        rx_seen = 1'b1; rx_resp = o_response; rx_crcerr = o_crcerr;
        rx_timeout = o_timeout; rx_busy = o_busy;
        break;
      end
      if (cyc == abort_at) break;
      i_start = (cyc == restart_at);
      if (cyc == restart_at) i_fifo = ~i_fifo;
      i_ll_stb = 1'b0;
      if (phase == 0) begin
        if (o_ll_stb) begin phase = 1; cnt = gap; end
      end else if (cnt > 0) begin
        i_ll_busy = 1'b1;
        cnt--;
      end else begin
        i_ll_busy = 1'b0;
        i_ll_stb = 1'b1;
        i_ll_byte = (idx < card_len) ? card[idx] : 8'hFF;
        idx++;
        if (o_ll_stb) cnt = gap; else phase = 0;
      end
    end
    i_start = 1'b0;
    i_ll_stb = 1'b0;
  endtask

  task automatic check_writes(input int n, input logic [7:0] base, input int first);
    chk("write_count", nwr, n);
    for (int i = 0; i < n && i < nwr; i++) begin
      chk("write_addr", wr_addr[i], base + 8'(i));
      chk("write_data", wr_data[i], {card[first+4*i], card[first+4*i+1],
                                     card[first+4*i+2], card[first+4*i+3]});
    end
  endtask

  // Card stream: FF, FF, FE, 00..0F, CRC hi, CRC lo.
  task automatic build_basic();
    card[0] = 8'hFF; card[1] = 8'hFF; card[2] = 8'hFE;
    for (int i = 0; i < 16; i++) card[3+i] = 8'(i);
    crc = crc_card(3, 16);
    card[19] = crc[15:8]; card[20] = crc[7:0];
    card_len = 21;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ll_stb", o_ll_stb, 1'b0);
    chk("rst_write", o_write, 1'b0);
    chk("rst_rxvalid", o_rxvalid, 1'b0);
    chk("rst_crcerr", o_crcerr, 1'b0);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_addr", o_addr, 8'h00);
    chk("ll_byte", o_ll_byte, 8'hFF);
    i_reset = 1'b0;

    // 16-byte block, good CRC; a start pulse mid-transfer must be ignored
    build_basic();
    do_start(4'd4, 1'b0);
    @(negedge i_clk);
    chk("busy_after_start", o_busy, 1'b1);
    run_xfer(0, 8, -1, 200);
    check_writes(4, 8'h00, 3);
    chk("t1_data0", wr_data[0], 32'h00010203);
    chk("t1_data3", wr_data[3], 32'h0C0D0E0F);
    chk("t1_rxvalid", rx_seen, 1'b1);
    chk("t1_response", rx_resp, 8'hFE);
    chk("t1_crcerr", rx_crcerr, 1'b0);
    chk("t1_timeout", rx_timeout, 1'b0);
    chk("t1_busy_at_rx", rx_busy, 1'b0);
    chk("t1_stb_drop_bytes", drop_idx, 21);
    @(negedge i_clk);
    chk("t1_rxvalid_pulse", o_rxvalid, 1'b0);

    // Same block, last CRC byte corrupted
    build_basic();
    card[20] = card[20] ^ 8'h01;
    do_start(4'd4, 1'b0);
    run_xfer(0, -1, -1, 200);
    check_writes(4, 8'h00, 3);
    chk("t2_rxvalid", rx_seen, 1'b1);
    chk("t2_crcerr", rx_crcerr, 1'b1);
    chk("t2_response", rx_resp, 8'hFE);
    repeat (3) @(negedge i_clk);
    chk("t2_crcerr_hold", o_crcerr, 1'b1);

    // lgblksz below range clamps to 16 bytes; upper half; stalled engine
    build_basic();
    do_start(4'd2, 1'b1);
    run_xfer(2, -1, -1, 400);
    check_writes(4, 8'h80, 3);
    chk("t3_rxvalid", rx_seen, 1'b1);
    chk("t3_crcerr", rx_crcerr, 1'b0);

    // 512-byte block into upper half; index must stop at 0xFF
    card[0] = 8'hFE;
    for (int i = 0; i < 512; i++) card[1+i] = 8'($urandom_range(0, 255));
    crc = crc_card(1, 512);
    card[513] = crc[15:8]; card[514] = crc[7:0];
    card_len = 515;
    do_start(4'd9, 1'b1);
    run_xfer(0, -1, -1, 2000);
    check_writes(128, 8'h80, 1);
    chk("t4_rxvalid", rx_seen, 1'b1);
    chk("t4_crcerr", rx_crcerr, 1'b0);
    chk("t4_response", rx_resp, 8'hFE);
    chk("t4_final_addr", o_addr, 8'hFF);

    // Data error token during token hunt
    card[0] = 8'hFF; card[1] = 8'h09; card_len = 2;
    do_start(4'd4, 1'b0);
    run_xfer(0, -1, -1, 200);
    chk("t5_writes", nwr, 0);
    chk("t5_rxvalid", rx_seen, 1'b1);
    chk("t5_response", rx_resp, 8'h09);
    chk("t5_crcerr", rx_crcerr, 1'b0);
    chk("t5_timeout", rx_timeout, 1'b0);
    chk("t5_stb_drop_bytes", drop_idx, 2);

    // Token timeout: card only sends FF (2^4 bytes)
    card_len = 0;
    do_start(4'd4, 1'b0);
    run_xfer(0, -1, -1, 200);
    chk("t6_writes", nwr, 0);
    chk("t6_rxvalid", rx_seen, 1'b1);
    chk("t6_timeout", rx_timeout, 1'b1);
    chk("t6_response", rx_resp, 8'hFF);
    chk("t6_stb_drop_bytes", drop_idx, 16);

    // Reset in the middle of DATA with the engine stalling
    build_basic();
    card[0] = 8'hFE;
    for (int i = 0; i < 16; i++) card[1+i] = 8'(i);
    crc = crc_card(1, 16);
    card[17] = crc[15:8]; card[18] = crc[7:0];
    card_len = 19;
    do_start(4'd4, 1'b0);
    run_xfer(2, -1, 14, 100);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("t7_busy_after_rst", o_busy, 1'b0);
    chk("t7_ll_stb_after_rst", o_ll_stb, 1'b0);
    chk("t7_rxvalid_after_rst", o_rxvalid, 1'b0);
    i_reset = 1'b0;
    i_ll_busy = 1'b0;
    saw_rx = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_rxvalid) saw_rx = 1'b1;
    end
    chk("t7_no_rxvalid", saw_rx, 1'b0);
    build_basic();
    do_start(4'd4, 1'b0);
    run_xfer(0, -1, -1, 200);
    check_writes(4, 8'h00, 3);
    chk("t7_rxvalid", rx_seen, 1'b1);
    chk("t7_crcerr", rx_crcerr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
